// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-stage program loader: FSM states and fixed byte values.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FILL,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0]  FILL_OPCODE  = 8'hFF;
    localparam logic [7:0]  CPU_BASE     = 8'h80;
    localparam int unsigned DEF_MAX_LEN  = 128;

endpackage

// File: rtl/prog_loader_wr.sv
// Registered program-memory write port, shared by the payload path and the fill path.
module prog_loader_wr
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = CPU_BASE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader; holds the CPU in reset until a checksum-valid image lands.
// Optional trailing 8'hFF fill of the ROM window: define PROG_LOADER_FILL_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = CPU_BASE,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       cpu_reset,
    output logic       done,
    output logic       error,
    output logic [7:0] load_count
);

    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    state_t     state;
    logic [7:0] len;
    logic [7:0] sum;
    logic       accept;
    logic [7:0] next_count;
    logic [7:0] csum_total;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
`ifdef PROG_LOADER_FILL_EN
    logic [8:0] fill_cnt;
`endif

    assign in_ready   = (state != S_RUN) && (state != S_FILL);
    assign accept     = in_valid && in_ready;
    assign next_count = load_count + 8'd1;
    assign csum_total = sum + in_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = BASE_ADDR + load_count;
        wr_data = in_data;
        if (state == S_DATA && accept) begin
            wr_en = 1'b1;
        end
`ifdef PROG_LOADER_FILL_EN
        // Fill cycles run while fill_cnt < MAX_LEN; one extra cycle lets the last strobe retire.
        if (state == S_FILL && fill_cnt < MAX_LEN9) begin
            wr_en   = 1'b1;
            wr_addr = BASE_ADDR + fill_cnt[7:0];
            wr_data = FILL_OPCODE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            sum        <= '0;
            load_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
`ifdef PROG_LOADER_FILL_EN
            fill_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state      <= S_LEN;
                        error      <= 1'b0;
                        load_count <= '0;
                        sum        <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (in_data == 8'd0 || {1'b0, in_data} > MAX_LEN9) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            len   <= in_data;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        load_count <= next_count;
                        sum        <= csum_total;
                        if (next_count == len) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (csum_total == 8'd0) begin
`ifdef PROG_LOADER_FILL_EN
                            if ({1'b0, len} == MAX_LEN9) begin
                                state     <= S_RUN;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state    <= S_FILL;
                                fill_cnt <= {1'b0, len};
                            end
`else
                            state     <= S_RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
`endif
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
`ifdef PROG_LOADER_FILL_EN
                    if (fill_cnt == MAX_LEN9) begin
                        state     <= S_RUN;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 9'd1;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    prog_loader_wr #(
        .BASE_ADDR(BASE_ADDR)
    ) u_wr (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level reference model checked every cycle plus literal pins.
module tb_prog_loader;

    localparam int PH_HUNT = 0;
    localparam int PH_LEN  = 1;
    localparam int PH_PAY  = 2;
    localparam int PH_CSUM = 3;
    localparam int PH_FILL = 4;
    localparam int PH_RUN  = 5;
    localparam int MAXL    = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [7:0] load_count;

    prog_loader #(
        .BASE_ADDR(8'h80),
        .MAX_LEN  (128),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: parses the accepted byte stream frame by frame.
    int         ph = PH_HUNT;
    int         m_len = 0;
    int         m_fill = 0;
    logic [7:0] m_sum = 8'h00;
    logic [7:0] m_lc = 8'h00;
    logic [7:0] m_addr = 8'h80;
    logic [7:0] m_wd = 8'h00;
    logic       m_we = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic       m_cpu = 1'b1;
    logic       m_valid = 1'b0;

    function automatic logic m_ready(input int p);
        return (p != PH_RUN) && (p != PH_FILL);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ph = PH_HUNT; m_len = 0; m_fill = 0; m_sum = 8'h00; m_lc = 8'h00;
            m_addr = 8'h80; m_wd = 8'h00; m_we = 1'b0;
            m_done = 1'b0; m_err = 1'b0; m_cpu = 1'b1; m_valid = 1'b1;
        end else begin
            m_we = 1'b0;
            if (ph == PH_FILL) begin
                if (m_fill > 0) begin
                    m_we = 1'b1;
                    m_addr = 8'(MAXL - m_fill) + 8'h80;
                    m_wd = 8'hFF;
                    m_fill--;
                end else begin
                    ph = PH_RUN; m_done = 1'b1; m_cpu = 1'b0;
                end
            end else if (m_ready(ph) && in_valid) begin
                case (ph)
                    PH_HUNT: if (in_data == 8'hA5) begin
                        ph = PH_LEN; m_err = 1'b0; m_lc = 8'h00; m_sum = 8'h00;
                    end
                    PH_LEN: if (in_data == 8'h00 || int'(in_data) > MAXL) begin
                        ph = PH_HUNT; m_err = 1'b1;
                    end else begin
                        m_len = int'(in_data); ph = PH_PAY;
                    end
                    PH_PAY: begin
                        m_we = 1'b1; m_addr = 8'h80 + m_lc; m_wd = in_data;
                        m_lc = m_lc + 8'd1; m_sum = m_sum + in_data;
                        if (int'(m_lc) == m_len) ph = PH_CSUM;
                    end
                    PH_CSUM: if (((int'(m_sum) + int'(in_data)) % 256) == 0) begin
`ifdef PROG_LOADER_FILL_EN
                        m_fill = MAXL - m_len;
                        if (m_fill == 0) begin ph = PH_RUN; m_done = 1'b1; m_cpu = 1'b0; end
                        else ph = PH_FILL;
`else
                        ph = PH_RUN; m_done = 1'b1; m_cpu = 1'b0;
`endif
                    end else begin
                        ph = PH_HUNT; m_err = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [7:0] mem_log [0:255];
    int         wcount = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready(ph)));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu));
            chk("load_count", 32'(load_count), 32'(m_lc));
            if (mem_we === 1'b1) begin
                mem_log[mem_addr] = mem_wdata;
                wcount++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wcount = 0;
        for (int a = 0; a < 256; a++) mem_log[a] = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c);
        send(8'hA5); send(8'h03); send(8'h1F); send(8'h86); send(8'h85); send(c);
    endtask

    // Checks the literal outcome of the A5,03,1F,86,85,D6 image.
    task automatic check_loaded(input string tag);
`ifdef PROG_LOADER_FILL_EN
        chk({tag, " in_ready during fill"}, 32'(in_ready), 32'd0);
        chk({tag, " cpu_reset during fill"}, 32'(cpu_reset), 32'd1);
        idle(130);
        chk({tag, " writes"}, 32'(wcount), 32'd128);
        chk({tag, " fill 83"}, 32'(mem_log[8'h83]), 32'hFF);
        chk({tag, " fill FF"}, 32'(mem_log[8'hFF]), 32'hFF);
`else
        chk({tag, " writes"}, 32'(wcount), 32'd3);
`endif
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, " load_count"}, 32'(load_count), 32'd3);
        chk({tag, " mem80"}, 32'(mem_log[8'h80]), 32'h1F);
        chk({tag, " mem81"}, 32'(mem_log[8'h81]), 32'h86);
        chk({tag, " mem82"}, 32'(mem_log[8'h82]), 32'h85);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_log[a] = 8'h00;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset mem_addr", 32'(mem_addr), 32'h80);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reset done", 32'(done), 32'd0);

        // 1: continuous valid frame, then input ignored once running
        send_frame(8'hD6);
        check_loaded("s1");
        send(8'hA5); send(8'h01);
        chk("s1 run holds done", 32'(done), 32'd1);
        chk("s1 run in_ready", 32'(in_ready), 32'd0);

        // 2: bad checksum, then recovery
        do_reset();
        send_frame(8'h00);
        idle(2);
        chk("s2 error", 32'(error), 32'd1);
        chk("s2 done", 32'(done), 32'd0);
        chk("s2 cpu_reset", 32'(cpu_reset), 32'd1);
        wcount = 0;
        send_frame(8'hD6);
        chk("s2 error cleared", 32'(error), 32'd0);
        check_loaded("s2");

        // 3: length boundaries
        do_reset();
        send(8'hA5); send(8'h00); idle(1);
        chk("s3 len0 error", 32'(error), 32'd1);
        send(8'hA5); send(8'h81); idle(1);
        chk("s3 len81 error", 32'(error), 32'd1);
        chk("s3 no writes", 32'(wcount), 32'd0);

        // 4: junk ahead of sync, gapped payload
        do_reset();
        send(8'h12); send(8'h34); idle(1);
        send(8'hA5); send(8'h03);
        send(8'h1F); idle(1); send(8'h86); idle(1); send(8'h85); idle(1);
        send(8'hD6);
        check_loaded("s4");

        // 5: reset with a write strobe pending
        do_reset();
        send(8'hA5); send(8'h03); send(8'h1F); send(8'h86);
        do_reset();
        chk("s5 in_ready", 32'(in_ready), 32'd1);
        chk("s5 cpu_reset", 32'(cpu_reset), 32'd1);
        chk("s5 load_count", 32'(load_count), 32'd0);
        chk("s5 mem_we", 32'(mem_we), 32'd0);
        send_frame(8'hD6);
        check_loaded("s5");

        // sync byte inside a frame is data: payload A5,5B sums to 0x100
        do_reset();
        send(8'hA5); send(8'h02); send(8'hA5); send(8'h5B); send(8'h00);
        idle(135);
        chk("s6 done", 32'(done), 32'd1);
        chk("s6 mem80", 32'(mem_log[8'h80]), 32'hA5);
        chk("s6 mem81", 32'(mem_log[8'h81]), 32'h5B);

        idle(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
